mailer_sched: RTL and testbench
===============================

Name: mailer_sched

Overview:
- Scheduler for the packet mailer (RAM1 -> RAM2 copy with start-byte/address/CRC check).
- Two upstream receive buffers (RAM1 halves) raise ready pulses. The block arbitrates them round-robin, steers the mailer onto the chosen buffer, sequences its start/run window and grades the result good or bad.
- Good packets are presented to the consumer and RAM2 stays locked until acknowledged; each buffer is then released upstream.

Parameters:
- DATAN, 255, mailer frame length minus 1; sets the run-wait window.
- START_LEN, 2, cycles mlr_start is held high after buf_sel changes (min 1).
- WAIT_EXTRA, 4, extra cycles beyond DATAN+2 allowed for the mlr_run pulse.
- ACK_TMO, 1023, consumer ack timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pkt_rdy  in  2  1-cycle pulse per buffer: buffer filled.
- mlr_run  in  1  mailer run pulse (packet valid); mailer updates on negedge, sampled here on posedge.
- cons_ack  in  1  consumer done with RAM2 (1-cycle pulse).
- mlr_start  out  1  mailer start/hold; high = mailer held idle.
- buf_sel  out  1  selects RAM1 buffer feeding the mailer.
- buf_free  out  2  1-cycle pulse: buffer released to upstream.
- pkt_valid  out  1  RAM2 holds a good packet.
- pkt_buf  out  1  source buffer of the presented packet.
- ok_cnt  out  16  good-packet count.
- err_cnt  out  16  bad-packet count.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: mlr_start=1, buf_sel=0, buf_free=0, pkt_valid=0, pkt_buf=0, ok_cnt=0, err_cnt=0, busy=0, pending=00, rr_last=1.
- Pending: pkt_rdy[i] sets pend[i]. pend[i] clears when buffer i is granted (IDLE->START).
  - A pulse arriving in the same cycle as the clear wins: pend stays 1.
  - A re-pulse for the in-flight buffer re-queues it.
- Arbitration in IDLE:
  - Only one pend bit set: grant that buffer.
  - Both set: grant !rr_last.
  - rr_last updates on each grant.
- FSM:
  - IDLE: mlr_start=1. On any pend -> START; buf_sel<=grant; cnt<=0.
  - START: mlr_start=1 for START_LEN cycles, then -> WAIT, cnt<=0.
  - WAIT: mlr_start=0. Mailer copies frame (DATAN+2 cycles).
    - mlr_run seen -> HOLD; ok_cnt+1; pkt_valid<=1; pkt_buf<=buf_sel.
    - cnt reaches DATAN+2+WAIT_EXTRA with no run -> RELEASE; err_cnt+1.
  - HOLD: mlr_start=1, pkt_valid=1. On cons_ack -> RELEASE; pkt_valid<=0.
  - RELEASE: buf_free[buf_sel] pulses for 1 cycle -> IDLE.
- Latency:
  - pkt_rdy to mlr_start falling edge = 2+START_LEN cycles.
  - mlr_run to pkt_valid = 1 cycle.
- Counters are saturating at 16'hFFFF.
- WAIT counter is 10 bits; DATAN+2+WAIT_EXTRA must not exceed 1023.
- Spurious signals are ignored:
  - mlr_run outside WAIT.
  - A second mlr_run in WAIT is ignored after the first.
  - cons_ack outside HOLD.
- rst_n low mid-operation returns to reset values immediately.
  - mlr_start goes high at once, aborting the mailer.
  - No buf_free is issued; upstream buffers are considered lost.

Optional Feature:
- Macro: MAILER_SCHED_ACK_TMO_EN.
- Defined: a 10-bit counter runs in HOLD.
  - On reaching ACK_TMO without cons_ack: pkt_valid drops, err_cnt increments, -> RELEASE.
  - cons_ack in the same cycle as timeout counts as ack, not error.
- Undefined: HOLD waits indefinitely; ACK_TMO is unused.

Test Plan:
- Single good frame:
  - Stimulus: pkt_rdy=01; mailer model pulses mlr_run at DATAN+3 cycles after mlr_start falls; cons_ack 10 cycles later.
  - Response: buf_sel=0, pkt_valid=1, pkt_buf=0, ok_cnt=1; buf_free=01 for 1 cycle; back to IDLE, busy=0.
- Bad frame: pkt_rdy=10, no mlr_run -> after DATAN+2+WAIT_EXTRA cycles err_cnt=1, buf_free=10, pkt_valid never 1.
- Simultaneous ready:
  - Stimulus: pkt_rdy=11 after reset, both frames good.
  - Response: buffer 0 served first (rr_last=1), then buffer 1; ok_cnt=2; buf_free pulses 01 then 10.
- Counter saturation: preload/force ok_cnt=16'hFFFE, run 3 good frames -> ok_cnt=16'hFFFF.
- Reset in WAIT: rst_n=0 at cnt=100 -> mlr_start=1 same cycle, pend=00, counters 0, no buf_free.
- Ack timeout (macro defined): ACK_TMO=50, no cons_ack -> 50 cycles into HOLD pkt_valid=0, err_cnt+1, buf_free pulse; cons_ack in the timeout cycle instead -> err_cnt unchanged.

Source files
------------

// File: rtl/mailer_sched.sv
// Round-robin scheduler steering the packet mailer over two RAM1 buffers.
// Optional consumer-ack timeout in HOLD: define MAILER_SCHED_ACK_TMO_EN.
module mailer_sched #(
   parameter int DATAN      = 255,
   parameter int START_LEN  = 2,
   parameter int WAIT_EXTRA = 4,
   parameter int ACK_TMO    = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  pkt_rdy,
   input  logic        mlr_run,
   input  logic        cons_ack,
   output logic        mlr_start,
   output logic        buf_sel,
   output logic [1:0]  buf_free,
   output logic        pkt_valid,
   output logic        pkt_buf,
   output logic [15:0] ok_cnt,
   output logic [15:0] err_cnt,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_HOLD,
      S_REL
   } state_t;

   localparam logic [9:0] SLIM = 10'(START_LEN - 1);
   localparam logic [9:0] WLIM = 10'(DATAN + 2 + WAIT_EXTRA - 1);

   if (START_LEN < 1 || DATAN + 2 + WAIT_EXTRA > 1023 ||
       ACK_TMO < 1 || ACK_TMO > 1023) begin : g_cfg_err
      $error("mailer_sched: parameter out of range");
   end

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [1:0]  pend_q, pend_d;
   logic [1:0]  pend_clr;
   logic        rr_q, rr_d;
   logic        grant;
   logic        buf_sel_q, buf_sel_d;
   logic        mlr_start_q, mlr_start_d;
   logic [1:0]  buf_free_q, buf_free_d;
   logic        pkt_valid_q, pkt_valid_d;
   logic        pkt_buf_q, pkt_buf_d;
   logic [15:0] ok_cnt_q, ok_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        busy_q, busy_d;
`ifdef MAILER_SCHED_ACK_TMO_EN
   localparam logic [9:0] TLIM = 10'(ACK_TMO - 1);
   logic [9:0]  tcnt_q, tcnt_d;
`endif

   always_comb begin
      case (pend_q)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         default: grant = ~rr_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_clr    = 2'b00;
      rr_d        = rr_q;
      buf_sel_d   = buf_sel_q;
      pkt_valid_d = pkt_valid_q;
      pkt_buf_d   = pkt_buf_q;
      ok_cnt_d    = ok_cnt_q;
      err_cnt_d   = err_cnt_q;
`ifdef MAILER_SCHED_ACK_TMO_EN
      tcnt_d      = tcnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d   = S_START;
               buf_sel_d = grant;
               rr_d      = grant;
               cnt_d     = '0;
               pend_clr  = grant ? 2'b10 : 2'b01;
            end
         end
         S_START: begin
            if (cnt_q == SLIM) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         S_WAIT: begin
            if (mlr_run) begin
               state_d     = S_HOLD;
               pkt_valid_d = 1'b1;
               pkt_buf_d   = buf_sel_q;
               if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
`ifdef MAILER_SCHED_ACK_TMO_EN
               tcnt_d = '0;
`endif
            end else if (cnt_q == WLIM) begin
               state_d = S_REL;
               if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         S_HOLD: begin
            // an ack landing on the timeout cycle still counts as an ack
            if (cons_ack) begin
               state_d     = S_REL;
               pkt_valid_d = 1'b0;
            end
`ifdef MAILER_SCHED_ACK_TMO_EN
            else if (tcnt_q == TLIM) begin
               state_d     = S_REL;
               pkt_valid_d = 1'b0;
               if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else begin
               tcnt_d = tcnt_q + 10'd1;
            end
`endif
         end
         S_REL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // a new ready pulse beats the grant clear
      pend_d      = (pend_q & ~pend_clr) | pkt_rdy;
      mlr_start_d = (state_d != S_WAIT);
      busy_d      = (state_d != S_IDLE);
      buf_free_d  = 2'b00;
      if (state_d == S_REL) buf_free_d = buf_sel_d ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pend_q      <= 2'b00;
         rr_q        <= 1'b1;
         buf_sel_q   <= 1'b0;
         mlr_start_q <= 1'b1;
         buf_free_q  <= 2'b00;
         pkt_valid_q <= 1'b0;
         pkt_buf_q   <= 1'b0;
         ok_cnt_q    <= '0;
         err_cnt_q   <= '0;
         busy_q      <= 1'b0;
`ifdef MAILER_SCHED_ACK_TMO_EN
         tcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         rr_q        <= rr_d;
         buf_sel_q   <= buf_sel_d;
         mlr_start_q <= mlr_start_d;
         buf_free_q  <= buf_free_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_buf_q   <= pkt_buf_d;
         ok_cnt_q    <= ok_cnt_d;
         err_cnt_q   <= err_cnt_d;
         busy_q      <= busy_d;
`ifdef MAILER_SCHED_ACK_TMO_EN
         tcnt_q      <= tcnt_d;
`endif
      end
   end

   assign mlr_start = mlr_start_q;
   assign buf_sel   = buf_sel_q;
   assign buf_free  = buf_free_q;
   assign pkt_valid = pkt_valid_q;
   assign pkt_buf   = pkt_buf_q;
   assign ok_cnt    = ok_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mailer_sched.sv
// Directed bench for mailer_sched with a simple in-line mailer model.
// Covers good/bad frames, round-robin, saturation, reset abort, ack timeout.
module tb_mailer_sched;

   localparam int DATAN = 255;
   localparam int SLEN  = 2;
   localparam int WEXT  = 4;
   localparam int TMO   = 50;
   localparam int WLIM  = DATAN + 2 + WEXT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  pkt_rdy;
   logic        mlr_run;
   logic        cons_ack;
   logic        mlr_start;
   logic        buf_sel;
   logic [1:0]  buf_free;
   logic        pkt_valid;
   logic        pkt_buf;
   logic [15:0] ok_cnt;
   logic [15:0] err_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mailer_sched #(
      .DATAN(DATAN), .START_LEN(SLEN),
      .WAIT_EXTRA(WEXT), .ACK_TMO(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pkt_rdy(pkt_rdy),
      .mlr_run(mlr_run), .cons_ack(cons_ack),
      .mlr_start(mlr_start), .buf_sel(buf_sel),
      .buf_free(buf_free), .pkt_valid(pkt_valid),
      .pkt_buf(pkt_buf), .ok_cnt(ok_cnt),
      .err_cnt(err_cnt), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Request (optional), wait for start to fall, then mailer run pulse.
   task automatic to_hold(input logic [1:0] rdy, input logic eb,
                          input int lat);
      int n;
      n = 0;
      pkt_rdy = rdy;
      do begin
         tick();
         pkt_rdy = 2'b00;
         n++;
      end while (mlr_start !== 1'b0 && n < 40);
      if (lat > 0) chk("start_latency", n, lat);
      chk("start_fall", {31'd0, mlr_start}, 0);
      chk("buf_sel", {31'd0, buf_sel}, {31'd0, eb});
      repeat (DATAN + 2) tick();
      chk("pv_early", {31'd0, pkt_valid}, 0);
      mlr_run = 1'b1;
      tick();
      mlr_run = 1'b0;
      chk("pv_set", {31'd0, pkt_valid}, 1);
      chk("pkt_buf", {31'd0, pkt_buf}, {31'd0, eb});
      chk("hold_start", {31'd0, mlr_start}, 1);
   endtask

   task automatic good_frame(input logic [1:0] rdy, input logic eb,
                             input int lat);
      logic [1:0] fr;
      fr = eb ? 2'b10 : 2'b01;
      to_hold(rdy, eb, lat);
      mlr_run = 1'b1;
      tick();
      mlr_run = 1'b0;
      repeat (8) tick();
      chk("pv_wait_ack", {31'd0, pkt_valid}, 1);
      cons_ack = 1'b1;
      tick();
      cons_ack = 1'b0;
      chk("buf_free", {30'd0, buf_free}, {30'd0, fr});
      chk("pv_clr", {31'd0, pkt_valid}, 0);
      tick();
      chk("buf_free_off", {30'd0, buf_free}, 0);
   endtask

   initial begin
      logic seen;
      rst_n    = 1'b0;
      pkt_rdy  = 2'b00;
      mlr_run  = 1'b0;
      cons_ack = 1'b0;
      repeat (3) tick();
      chk("rst_mlr_start", {31'd0, mlr_start}, 1);
      chk("rst_buf_sel", {31'd0, buf_sel}, 0);
      chk("rst_buf_free", {30'd0, buf_free}, 0);
      chk("rst_pv", {31'd0, pkt_valid}, 0);
      chk("rst_pkt_buf", {31'd0, pkt_buf}, 0);
      chk("rst_ok", {16'd0, ok_cnt}, 0);
      chk("rst_err", {16'd0, err_cnt}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      tick();

      mlr_run  = 1'b1;
      cons_ack = 1'b1;
      tick();
      mlr_run  = 1'b0;
      cons_ack = 1'b0;
      tick();
      chk("spur_busy", {31'd0, busy}, 0);
      chk("spur_ok", {16'd0, ok_cnt}, 0);
      chk("spur_start", {31'd0, mlr_start}, 1);

      good_frame(2'b01, 1'b0, 2 + SLEN);
      chk("g1_ok", {16'd0, ok_cnt}, 1);
      chk("g1_err", {16'd0, err_cnt}, 0);
      chk("g1_busy", {31'd0, busy}, 0);

      do_reset();
      good_frame(2'b11, 1'b0, 0);
      good_frame(2'b00, 1'b1, 0);
      chk("rr_ok", {16'd0, ok_cnt}, 2);
      chk("rr_busy", {31'd0, busy}, 0);

      seen = 1'b0;
      pkt_rdy = 2'b10;
      tick();
      pkt_rdy = 2'b00;
      repeat (SLEN + 1) tick();
      chk("bad_start_fall", {31'd0, mlr_start}, 0);
      chk("bad_buf_sel", {31'd0, buf_sel}, 1);
      repeat (WLIM - 1) begin
         tick();
         seen = seen | pkt_valid;
      end
      chk("bad_no_free_yet", {30'd0, buf_free}, 0);
      chk("bad_err_yet", {16'd0, err_cnt}, 0);
      tick();
      seen = seen | pkt_valid;
      chk("bad_free", {30'd0, buf_free}, 2'b10);
      chk("bad_err", {16'd0, err_cnt}, 1);
      chk("bad_pv_never", {31'd0, seen}, 0);
      tick();
      chk("bad_idle", {31'd0, busy}, 0);
      chk("bad_ok", {16'd0, ok_cnt}, 2);

      force dut.ok_cnt_q = 16'hFFFE;
      tick();
      release dut.ok_cnt_q;
      tick();
      chk("sat_preload", {16'd0, ok_cnt}, 16'hFFFE);
      good_frame(2'b01, 1'b0, 0);
      chk("sat_1", {16'd0, ok_cnt}, 16'hFFFF);
      good_frame(2'b01, 1'b0, 0);
      good_frame(2'b01, 1'b0, 0);
      chk("sat_3", {16'd0, ok_cnt}, 16'hFFFF);

      pkt_rdy = 2'b01;
      tick();
      pkt_rdy = 2'b00;
      repeat (SLEN + 1) tick();
      repeat (50) tick();
      pkt_rdy = 2'b10;
      tick();
      pkt_rdy = 2'b00;
      repeat (49) tick();
      chk("rw_in_wait", {31'd0, mlr_start}, 0);
      rst_n = 1'b0;
      #1;
      chk("rw_start", {31'd0, mlr_start}, 1);
      chk("rw_pend", {30'd0, dut.pend_q}, 0);
      chk("rw_ok", {16'd0, ok_cnt}, 0);
      chk("rw_err", {16'd0, err_cnt}, 0);
      chk("rw_busy", {31'd0, busy}, 0);
      seen = 1'b0;
      repeat (2) begin
         tick();
         seen = seen | (|buf_free);
      end
      rst_n = 1'b1;
      repeat (4) begin
         tick();
         seen = seen | (|buf_free);
      end
      chk("rw_no_free", {31'd0, seen}, 0);
      chk("rw_idle", {31'd0, busy}, 0);

`ifdef MAILER_SCHED_ACK_TMO_EN
      to_hold(2'b01, 1'b0, 0);
      repeat (TMO - 1) tick();
      chk("tmo_pv_before", {31'd0, pkt_valid}, 1);
      tick();
      chk("tmo_pv", {31'd0, pkt_valid}, 0);
      chk("tmo_err", {16'd0, err_cnt}, 1);
      chk("tmo_free", {30'd0, buf_free}, 2'b01);
      tick();
      to_hold(2'b10, 1'b1, 0);
      repeat (TMO - 1) tick();
      cons_ack = 1'b1;
      tick();
      cons_ack = 1'b0;
      chk("tmo_ack_pv", {31'd0, pkt_valid}, 0);
      chk("tmo_ack_err", {16'd0, err_cnt}, 1);
      chk("tmo_ack_free", {30'd0, buf_free}, 2'b10);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
